load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/data_ram.sv | 27 ++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes and FSM states.
// The register file imports the load codes from here so that both sides agree
// on which loads it must sign-extend.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/data_ram.sv
// MEM_WORDS x 32 synchronous data RAM with per-byte write enables and a
// registered read port. Contents are deliberately never reset.
module data_ram #(
    parameter int MEM_WORDS = 256,
    parameter int IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    input  logic             re,
    output logic [31:0]      rdata
);

    logic [31:0] mem [MEM_WORDS];

    // Byte-masked write and one-cycle registered read on the same index.
    always_ff @(posedge clk) begin
        if (we && be[0]) mem[addr][7:0]   <= wdata[7:0];
        if (we && be[1]) mem[addr][15:8]  <= wdata[15:8];
        if (we && be[2]) mem[addr][23:16] <= wdata[23:16];
        if (we && be[3]) mem[addr][31:24] <= wdata[31:24];
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: decodes one request at a time, checks alignment, width code
// and range, formats store lanes into the data RAM and extracts load data back
// out, returning a single-cycle response pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_error
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_W-1:0] MEM_WORDS_A = ADDR_W'(MEM_WORDS);

    lsu_state_e  state;
    logic [2:0]  p_funct3;
    logic [1:0]  p_off;
    logic        accept;
    logic        misaligned;
    logic        bad_funct3;
    logic        out_of_range;
    logic        req_error;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;
    logic [31:0] ld_data;

    assign accept = req_valid && req_ready && !reset;

    // Full word index is compared before truncation so high addresses never alias.
    assign out_of_range = {2'b00, req_addr[ADDR_W-1:2]} >= MEM_WORDS_A;
    assign req_error    = misaligned || bad_funct3 || out_of_range;

    // Classify the incoming request: alignment against its width, legal width code.
    always_comb begin
        misaligned = 1'b0;
        bad_funct3 = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (req_write)
            bad_funct3 = !(req_funct3 inside {SB, SH, SW});
        else
            bad_funct3 = (req_funct3 inside {3'b011, 3'b110, 3'b111});
    end

    // Replicate store data across lanes and pick the byte enables from the offset.
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = req_wdata;
        case (req_funct3)
            SB: begin
                st_be    = 4'b0001 << req_addr[1:0];
                st_wdata = {4{req_wdata[7:0]}};
            end
            SH: begin
                st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{req_wdata[15:0]}};
            end
            SW: begin
                st_be    = 4'b1111;
                st_wdata = req_wdata;
            end
            default: st_be = 4'b0000;
        endcase
    end

    assign ram_we = accept &&  req_write && !req_error;
    assign ram_re = accept && !req_write && !req_error;

    data_ram #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (st_be),
        .addr  (req_addr[IDX_W+1:2]),
        .wdata (st_wdata),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    // Right-justify and zero-extend the loaded lane using the captured request fields.
    always_comb begin
        ld_data = 32'h0;
        case (p_funct3)
            LB, LBU: ld_data = {24'h0, 8'(ram_rdata >> {p_off, 3'b000})};
            LH, LHU: ld_data = {16'h0, 16'(ram_rdata >> {p_off[1], 4'b0000})};
            LW:      ld_data = ram_rdata;
            default: ld_data = 32'h0;
        endcase
    end

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= 32'h0;
            resp_error <= 1'b0;
            p_funct3   <= 3'b000;
            p_off      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    resp_data  <= 32'h0;
                    resp_error <= 1'b0;
                    if (accept) begin
                        p_funct3  <= req_funct3;
                        p_off     <= req_addr[1:0];
                        req_ready <= 1'b0;
                        if (req_error || req_write) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_error <= req_error;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    state      <= DONE;
                    resp_valid <= 1'b1;
                    resp_data  <= ld_data;
                    resp_error <= 1'b0;
                end
                DONE: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_data  <= 32'h0;
                    resp_error <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_data  <= 32'h0;
                    resp_error <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: each task drives one scenario and
// compares the response against hand-computed values.
module tb_load_store_unit;

    localparam int MEM_WORDS = 256;
    localparam int ADDR_W    = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              resp_error;

    int checks = 0;
    int errors = 0;

    load_store_unit #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_error (resp_error)
    );

    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for its response; lat counts edges from acceptance.
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] data, output logic err,
                          output int lat);
        int w;
        data = 32'h0;
        err  = 1'b0;
        lat  = 0;
        @(negedge clk);
        w = 0;
        while (req_ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (req_ready !== 1'b1) begin
            checks++; errors++;
            $display("[TB] FAIL ready_timeout: req_ready=%b required 1", req_ready);
            return;
        end
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_write  = ~wr;
        req_funct3 = 3'b111;
        req_addr   = ~addr;
        req_wdata  = ~wd;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (resp_valid !== 1'b1) begin
            checks++; errors++;
            $display("[TB] FAIL resp_timeout: resp_valid=%b required 1", resp_valid);
            lat = 0;
            return;
        end
        data = resp_data;
        err  = resp_error;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b required 0", resp_valid); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_resp_data: got %h required 0", resp_data); end
        checks++; if (resp_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_error: got %b required 0", resp_error); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_sw_lw();
        logic [31:0] d; logic e; int l;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, e, l);
        checks++; if (l !== 1 || e !== 1'b0) begin errors++; $display("[TB] FAIL sw_latency: lat=%0d err=%b required lat=1 err=0", l, e); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, d, e, l);
        checks++; if (l !== 2) begin errors++; $display("[TB] FAIL lw_latency: got %0d required 2", l); end
        checks++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("[TB] FAIL lw_data: got %h err=%b required deadbeef err=0", d, e); end
    endtask

    task automatic test_byte();
        logic [31:0] d; logic e; int l;
        do_req(1'b1, 3'b010, 32'h10, 32'h00000000, d, e, l);
        do_req(1'b1, 3'b000, 32'h13, 32'hFFFFFF5A, d, e, l);
        checks++; if (l !== 1 || e !== 1'b0) begin errors++; $display("[TB] FAIL sb_resp: lat=%0d err=%b required lat=1 err=0", l, e); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, d, e, l);
        checks++; if (d !== 32'h5A000000) begin errors++; $display("[TB] FAIL sb_lw_word: got %h required 5a000000", d); end
        do_req(1'b0, 3'b100, 32'h13, 32'h0, d, e, l);
        checks++; if (d !== 32'h0000005A || e !== 1'b0) begin errors++; $display("[TB] FAIL lbu_13: got %h required 0000005a", d); end
        do_req(1'b0, 3'b001, 32'h12, 32'h0, d, e, l);
        checks++; if (d !== 32'h00005A00) begin errors++; $display("[TB] FAIL lh_12: got %h required 00005a00", d); end
    endtask

    task automatic test_half();
        logic [31:0] d; logic e; int l;
        do_req(1'b1, 3'b010, 32'h20, 32'h00000000, d, e, l);
        do_req(1'b1, 3'b001, 32'h22, 32'h12348001, d, e, l);
        do_req(1'b0, 3'b101, 32'h22, 32'h0, d, e, l);
        checks++; if (d !== 32'h00008001 || e !== 1'b0) begin errors++; $display("[TB] FAIL lhu_22: got %h required 00008001", d); end
        do_req(1'b0, 3'b001, 32'h21, 32'h0, d, e, l);
        checks++; if (e !== 1'b1 || d !== 32'h0 || l !== 1) begin errors++; $display("[TB] FAIL lh_misaligned: err=%b data=%h lat=%0d required err=1 data=0 lat=1", e, d, l); end
        do_req(1'b0, 3'b010, 32'h20, 32'h0, d, e, l);
        checks++; if (d !== 32'h80010000) begin errors++; $display("[TB] FAIL sh_word_after: got %h required 80010000", d); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e; int l;
        do_req(1'b1, 3'b010, 32'h4, 32'h00000077, d, e, l);
        do_req(1'b1, 3'b010, 32'h6, 32'h00000BAD, d, e, l);
        checks++; if (e !== 1'b1 || l !== 1 || d !== 32'h0) begin errors++; $display("[TB] FAIL sw_misaligned: err=%b lat=%0d data=%h required err=1 lat=1 data=0", e, l, d); end
        do_req(1'b0, 3'b010, 32'h4, 32'h0, d, e, l);
        checks++; if (d !== 32'h00000077) begin errors++; $display("[TB] FAIL sw_misaligned_nowrite: got %h required 00000077", d); end
        do_req(1'b1, 3'b010, 32'h0, 32'h0000A0A0, d, e, l);
        do_req(1'b1, 3'b010, MEM_WORDS * 4, 32'hFFFFFFFF, d, e, l);
        checks++; if (e !== 1'b1 || l !== 1) begin errors++; $display("[TB] FAIL sw_out_of_range: err=%b lat=%0d required err=1 lat=1", e, l); end
        do_req(1'b0, 3'b010, 32'h0, 32'h0, d, e, l);
        checks++; if (d !== 32'h0000A0A0) begin errors++; $display("[TB] FAIL out_of_range_nowrap: got %h required 0000a0a0", d); end
        do_req(1'b1, 3'b010, MEM_WORDS * 4 - 4, 32'h600DF00D, d, e, l);
        do_req(1'b0, 3'b010, MEM_WORDS * 4 - 4, 32'h0, d, e, l);
        checks++; if (d !== 32'h600DF00D || e !== 1'b0) begin errors++; $display("[TB] FAIL last_word: got %h err=%b required 600df00d err=0", d, e); end
        do_req(1'b1, 3'b011, 32'h8, 32'h1, d, e, l);
        checks++; if (e !== 1'b1) begin errors++; $display("[TB] FAIL store_f3_011: err=%b required 1", e); end
        do_req(1'b1, 3'b100, 32'h8, 32'h1, d, e, l);
        checks++; if (e !== 1'b1) begin errors++; $display("[TB] FAIL store_f3_100: err=%b required 1", e); end
        do_req(1'b0, 3'b110, 32'h8, 32'h0, d, e, l);
        checks++; if (e !== 1'b1 || d !== 32'h0 || l !== 1) begin errors++; $display("[TB] FAIL load_f3_110: err=%b data=%h lat=%0d required err=1 data=0 lat=1", e, d, l); end
    endtask

    task automatic test_reset_with_request();
        logic [31:0] d; logic e; int l;
        do_req(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, d, e, l);
        @(negedge clk);
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'h11111111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b0;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ignored: ready=%b resp_valid=%b required 1 0", req_ready, resp_valid); end
        do_req(1'b0, 3'b010, 32'h40, 32'h0, d, e, l);
        checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL reset_keeps_ram: got %h required cafef00d", d); end
    endtask

    task automatic test_reset_in_read();
        logic [31:0] d; logic e; int l;
        do_req(1'b1, 3'b010, 32'h30, 32'h13572468, d, e, l);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h30;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_read_pulse: resp_valid=%b required 0", resp_valid); end
        @(negedge clk);
        reset = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_read_ready: got %b required 1", req_ready); end
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_read_late: resp_valid=%b required 0", resp_valid); end
        do_req(1'b0, 3'b010, 32'h30, 32'h0, d, e, l);
        checks++; if (d !== 32'h13572468 || e !== 1'b0 || l !== 2) begin errors++; $display("[TB] FAIL reset_in_read_next: data=%h lat=%0d required 13572468 lat=2", d, l); end
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp_q[$];
        logic [32:0] exp_item;
        logic [31:0] last_store;
        logic        prev_resp;
        logic        advance;
        logic        done;
        int          k, accepts, resps, gap, exp_gap, drain;
        k = 0; accepts = 0; resps = 0; gap = 0; exp_gap = 0; drain = 0;
        prev_resp = 1'b0; done = 1'b0; last_store = 32'h0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h50;
        req_wdata  = 32'h10000000;
        for (int c = 0; c < 80 && !(done && drain > 5); c++) begin
            if (resp_valid === 1'b1) begin
                resps++;
                checks++; if (prev_resp === 1'b1) begin errors++; $display("[TB] FAIL b2b_consecutive: resp_valid high two cycles in a row"); end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL b2b_spurious: resp_valid=1 required 0 (no pending request)");
                end else begin
                    exp_item = exp_q.pop_front();
                    if (resp_data !== exp_item[31:0] || resp_error !== exp_item[32]) begin
                        errors++; $display("[TB] FAIL b2b_resp: data=%h err=%b required %h err=%b", resp_data, resp_error, exp_item[31:0], exp_item[32]);
                    end
                end
            end
            prev_resp = resp_valid;
            advance = 1'b0;
            if (req_valid === 1'b1 && req_ready === 1'b1) begin
                if (accepts > 0) begin
                    checks++; if (gap !== exp_gap) begin errors++; $display("[TB] FAIL b2b_interval: got %0d required %0d", gap, exp_gap); end
                end
                if (req_write) begin
                    exp_q.push_back({1'b0, 32'h0});
                    last_store = req_wdata;
                    exp_gap = 2;
                end else begin
                    exp_q.push_back({1'b0, last_store});
                    exp_gap = 3;
                end
                accepts++;
                gap = 0;
                advance = 1'b1;
            end
            @(posedge clk); #1;
            gap++;
            if (done) drain++;
            if (advance) begin
                k++;
                if (accepts >= 10) begin
                    req_valid = 1'b0;
                    done = 1'b1;
                end else begin
                    req_write = (k % 2 == 0);
                    req_wdata = 32'h10000000 + k;
                    req_funct3 = 3'b010;
                end
            end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_timeout: accepts=%0d required 10", accepts); end
        checks++; if (resps !== accepts || exp_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_count: resps=%0d required %0d", resps, accepts); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = 32'h0;
        $display("[TB] starting load_store_unit bench");
        test_reset();
        test_sw_lw();
        test_byte();
        test_half();
        test_errors();
        test_reset_with_request();
        test_reset_in_read();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
